// File: rtl/vga_timing_gen_if.sv
// vga_if: one pixel's raster position, syncs, blanks and colour.
// Modport out for the timing source, modport in for draw stages.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport out (
    output vcount, vsync, vblnk,
    output hcount, hsync, hblnk,
    output rgb
  );

  modport in (
    input vcount, vsync, vblnk,
    input hcount, hsync, hblnk,
    input rgb
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync pulses and blanks for the video head.
// Define VGA_TIMING_TEST_PATTERN_EN to drive 8 vertical colour bars on rgb.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int SYNC_POL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  vga_if.out          vga_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_MAX  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_ON  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_ON  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        POL    = (SYNC_POL != 0);

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  logic [10:0] hcount_n;
  logic [10:0] vcount_n;
  logic        hsync_n;
  logic        vsync_n;
  logic        hblnk_n;
  logic        vblnk_n;
  logic [11:0] rgb_n;
  logic        hwrap;
  logic        vwrap;

  assign hwrap = (hcount == H_MAX);
  assign vwrap = (vcount == V_MAX);

  always_comb begin
    hcount_n = hcount + 11'd1;
    vcount_n = vcount;
    if (hwrap) begin
      hcount_n = '0;
      vcount_n = vwrap ? '0 : vcount + 11'd1;
    end
  end

  // Flags are derived from the next position so they land with it.
  assign hblnk_n = (hcount_n >= H_VIS);
  assign vblnk_n = (vcount_n >= V_VIS);
  assign hsync_n = ((hcount_n >= HS_ON) && (hcount_n <= HS_OFF)) ~^ POL;
  assign vsync_n = ((vcount_n >= VS_ON) && (vcount_n <= VS_OFF)) ~^ POL;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

  logic [2:0]  bar;
  logic [11:0] bar_rgb;

  assign bar = 3'(hcount_n / BAR_W);

  always_comb begin
    bar_rgb = 12'h000;
    case (bar)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  end

  assign rgb_n = (hblnk_n || vblnk_n) ? 12'h000 : bar_rgb;
`else
  assign rgb_n = 12'h000;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~POL;
      vsync       <= ~POL;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else if (en) begin
      hcount      <= hcount_n;
      vcount      <= vcount_n;
      hsync       <= hsync_n;
      vsync       <= vsync_n;
      hblnk       <= hblnk_n;
      vblnk       <= vblnk_n;
      rgb         <= rgb_n;
      frame_start <= hwrap && vwrap;
      if (hwrap && vwrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end else begin
      frame_start <= 1'b0;
    end
  end

  assign vga_out.hcount = hcount;
  assign vga_out.vcount = vcount;
  assign vga_out.hsync  = hsync;
  assign vga_out.vsync  = vsync;
  assign vga_out.hblnk  = hblnk;
  assign vga_out.vblnk  = vblnk;
  assign vga_out.rgb    = rgb;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the VGA interface: generates the raster counters, sync pulses and blanking flags that every downstream draw stage consumes through the interface's input modport.
- Drives the interface's output modport with pixel rgb forced to black (or a test pattern).
- Sits at the head of the video pipeline, clocked by the pixel clock (40 MHz for the 800x600@60 default).

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, 1 = sync asserted high, 0 = asserted low
- Derived: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 1056; V_TOTAL = 628. Both must be ≤ 2048 (11-bit counters).

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous, active-high reset
- en  input  1  pixel advance enable; counters hold while low
- vga_out  vga_if.out  interface  vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]
- frame_start  output  1  one-cycle pulse when the raster enters pixel (0,0)
- frame_cnt  output  16  completed-frame counter, wraps modulo 2^16

Behaviour:
- All outputs are registered. Interface fields in a given cycle describe one single pixel, so hcount/vcount, syncs, blanks and rgb are mutually consistent with zero skew.
- Reset (rst=1 at a clk edge):
  - hcount=0, vcount=0, hblnk=0, vblnk=0, frame_cnt=0, frame_start=0, rgb=0.
  - hsync and vsync are driven to their deasserted level (0 if SYNC_POL=1, 1 if SYNC_POL=0).
  - Reset has priority over en.
- Counter advance (en=1, rst=0):
  - hcount increments by 1.
  - When hcount = H_TOTAL-1: hcount wraps to 0 and vcount increments.
  - When vcount = V_TOTAL-1 at the same time: vcount wraps to 0.
  - Pixel order: raster scan.
- en=0: all outputs hold their current values; frame_start is forced to 0 (no repeated pulse).
- Flags, evaluated on the next-state counter values so they are registered alongside them:
  - hblnk = (hcount ≥ H_ACTIVE); vblnk = (vcount ≥ V_ACTIVE).
  - hsync active when H_ACTIVE+H_FP ≤ hcount ≤ H_ACTIVE+H_FP+H_SYNC-1 (840..967 by default).
  - vsync active when V_ACTIVE+V_FP ≤ vcount ≤ V_ACTIVE+V_FP+V_SYNC-1 (601..604 by default).
- frame_start:
  - 1 for exactly one advancing cycle, the one in which the registered counters become (0,0) after a wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted on the first cycle after reset.
- frame_cnt: increments in the same cycle frame_start asserts; wraps 0xFFFF→0x0000.
- rgb = 12'h000 in every cycle (feature off).
- Reset mid-frame: counters return to (0,0) on the next edge with no frame_start. Advancing resumes from (1,0) on the first en=1 cycle after rst deasserts.
- No combinational path from any input to any output.

Optional Feature:
- Macro: VGA_TIMING_TEST_PATTERN_EN.
- Defined:
  - rgb carries 8 vertical colour bars, each H_ACTIVE/8 = 100 pixels wide. Bar index = hcount/100, values 0..7.
  - Bar colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - rgb = 000 whenever hblnk or vblnk.
  - rgb is registered with the counters, same cycle.
- Undefined: rgb constant 12'h000. No pattern logic is synthesised.

Test Plan:
- Reset, then en=1 continuously for 1056 cycles:
  - hcount sequences 0..1055 then 0; vcount steps 0→1 on the wrap cycle.
  - hblnk=1 exactly for hcount 800..1055.
  - hsync=1 exactly for hcount 840..967 (128 cycles).
- Run 2 full frames (2×1056×628 advancing cycles):
  - vsync=1 for vcount 601..604 (4×1056 cycles per frame); vblnk=1 for vcount 600..627.
  - frame_start pulses exactly twice, 663168 cycles apart; frame_cnt reads 2.
- Toggle en low for 5 cycles at (hcount=500, vcount=10): all outputs frozen for those 5 cycles, then advancing resumes at hcount=501.
- Assert rst for 1 cycle at (hcount=900, vcount=602, hsync=vsync=1):
  - Next cycle: counters 0, syncs 0, frame_cnt 0, frame_start 0.
  - Repeat with SYNC_POL=0: syncs read 1 after reset and are active low at the same counts.
- With VGA_TIMING_TEST_PATTERN_EN defined:
  - rgb=FFF at (0,0), FF0 at (100,0), 000 at (799,0) and at (800,0) (blank), F00 at (550,300).
- Without VGA_TIMING_TEST_PATTERN_EN: rgb=000 at every sampled pixel over a full frame.
